// File: rtl/psram_async_ctrl_if.sv
// Request/response channel between a client and psram_async_ctrl.
// Macro: none (the controller's PSRAM_PAGE_READ_EN does not change this interface).
// Signals:
//   req_valid/req_ready : request handshake, accepted when both are 1 on a rising clk edge
//   req_we              : 1=write, 0=read
//   req_burst           : page-read request (4 words), honoured only in page-mode builds
//   req_addr            : word address, ADDR_W bits
//   req_wdata           : 16-bit write data
//   req_be              : byte enables, [1]=upper [0]=lower, active-high
//   rsp_valid/rsp_rdata : one-cycle pulse per returned read word
// Modports: master = client side, slave = controller side.
interface psram_async_ctrl_if #(
  parameter int unsigned ADDR_W = 23
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_burst;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_burst, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_burst, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/psram_async_ctrl.sv
// Asynchronous-mode PSRAM (Cellular RAM) controller: turns single-word
// read/write requests into OE/WE/CS strobe sequences with fixed wait counts.
// Optional macro PSRAM_PAGE_READ_EN adds 4-word page-mode reads (req_burst=1).
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   bus (slave)        : request/response channel, see psram_async_ctrl_if
//   MemAdr, MemDB      : memory address bus, bidirectional data bus
//   MemOE, MemWR, RamCS: active-low output-enable, write-enable, chip-select
//   RamLB, RamUB       : active-low byte lanes
//   RamAdv, RamClk, RamCRE, FlashCS, FlashRp : static ties for async mode / flash deselect
// Parameters: ADDR_W, RD_WAIT (1..15), WR_WAIT (1..15), RECOV (1..7).
module psram_async_ctrl #(
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned RD_WAIT = 4,
  parameter int unsigned WR_WAIT = 4,
  parameter int unsigned RECOV   = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  psram_async_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0]     MemAdr,
  inout  wire  [15:0]           MemDB,
  output logic                  MemOE,
  output logic                  MemWR,
  output logic                  RamCS,
  output logic                  RamLB,
  output logic                  RamUB,
  output logic                  RamAdv,
  output logic                  RamClk,
  output logic                  RamCRE,
  output logic                  FlashCS,
  output logic                  FlashRp
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;
  localparam int unsigned BEAT_W = 2;

`ifdef PSRAM_PAGE_READ_EN
  localparam bit PAGE_EN = 1'b1;
`else
  localparam bit PAGE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RECOV = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_n_q, be_n_d;
  logic                burst_q, burst_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                oe_n_q, oe_n_d;
  logic                wr_n_q, wr_n_d;
  logic                cs_n_q, cs_n_d;
  logic                drive_q, drive_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_n_q      <= '1;
      burst_q     <= 1'b0;
      beat_q      <= '0;
      oe_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_n_q      <= be_n_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      oe_n_q      <= oe_n_d;
      wr_n_q      <= wr_n_d;
      cs_n_q      <= cs_n_d;
      drive_q     <= drive_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next state and next values of every registered output.
  // The IDLE cycle doubles as the last recovery cycle, so ST_RECOV only
  // exists for RECOV > 1 and a new access can start RD_WAIT+RECOV edges
  // after the previous accept.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_n_d      = be_n_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    oe_n_d      = oe_n_q;
    wr_n_d      = wr_n_q;
    cs_n_d      = cs_n_q;
    drive_d     = 1'b0;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        cs_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        if (bus.req_valid && ready_q) begin
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_n_d  = ~bus.req_be;
          burst_d = PAGE_EN && bus.req_burst;
          beat_d  = '0;
          if (bus.req_we) begin
            state_d = ST_WRITE;
            wr_n_d  = 1'b0;
            drive_d = 1'b1;
            cnt_d   = CNT_W'(WR_WAIT);
          end else begin
            state_d = ST_READ;
            oe_n_d  = 1'b0;
            cnt_d   = CNT_W'(RD_WAIT);
          end
        end
      end

      ST_READ: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_valid_d = 1'b1;
          rdata_d     = MemDB;
          if (burst_q && (beat_q != BEAT_W'(3))) begin
            // Page mode: OE stays low, next word one cycle later, address wraps in page.
            beat_d      = beat_q + BEAT_W'(1);
            addr_d[1:0] = addr_q[1:0] + 2'(1);
            cnt_d       = CNT_W'(1);
          end else begin
            cnt_d  = '0;
            oe_n_d = 1'b1;
            cs_n_d = 1'b1;
            if (RECOV > 1) begin
              state_d = ST_RECOV;
              cnt_d   = CNT_W'(RECOV - 1);
            end else begin
              state_d = ST_IDLE;
              ready_d = 1'b1;
            end
          end
        end
      end

      ST_WRITE: begin
        // Data stays on the bus through the first cycle after MemWR rises.
        drive_d = 1'b1;
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d  = '0;
          wr_n_d = 1'b1;
          cs_n_d = 1'b1;
          if (RECOV > 1) begin
            state_d = ST_RECOV;
            cnt_d   = CNT_W'(RECOV - 1);
          end else begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end
        end
      end

      ST_RECOV: begin
        cs_n_d = 1'b1;
        oe_n_d = 1'b1;
        wr_n_d = 1'b1;
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
    endcase
  end

  // Output mapping.
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;

  assign MemAdr = addr_q;
  assign MemDB  = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign MemOE  = oe_n_q;
  assign MemWR  = wr_n_q;
  assign RamCS  = cs_n_q;
  assign RamLB  = be_n_q[0];
  assign RamUB  = be_n_q[1];

  // Async mode, flash deselected.
  assign RamAdv  = 1'b0;
  assign RamClk  = 1'b0;
  assign RamCRE  = 1'b0;
  assign FlashCS = 1'b1;
  assign FlashRp = 1'b1;

endmodule

// File: tb/tb_psram_async_ctrl.sv
// Bench for psram_async_ctrl: a cycle-level model derived from the access
// rules (offsets from the accept edge) is compared against the DUT every
// cycle, plus directed transactions with hand-computed literal results.
module tb_psram_async_ctrl;
  localparam int AW = 23;
  localparam int RD = 4;
  localparam int WR = 4;
  localparam int RC = 1;
`ifdef PSRAM_PAGE_READ_EN
  localparam bit PAGE = 1'b1;
`else
  localparam bit PAGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [AW-1:0] MemAdr;
  wire  [15:0]   MemDB;
  logic MemOE, MemWR, RamCS, RamLB, RamUB, RamAdv, RamClk, RamCRE, FlashCS, FlashRp;

  psram_async_ctrl_if #(.ADDR_W(AW)) bus ();

  psram_async_ctrl #(.ADDR_W(AW), .RD_WAIT(RD), .WR_WAIT(WR), .RECOV(RC)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .MemAdr(MemAdr), .MemDB(MemDB), .MemOE(MemOE), .MemWR(MemWR), .RamCS(RamCS),
    .RamLB(RamLB), .RamUB(RamUB), .RamAdv(RamAdv), .RamClk(RamClk), .RamCRE(RamCRE),
    .FlashCS(FlashCS), .FlashRp(FlashRp)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] init_val(input int i);
    return (i == 16) ? 16'hBEEF : (16'h1200 | 16'(i));
  endfunction

  // ---------------- memory device (async SRAM behaviour) ----------------
  logic [15:0] dev_mem [64];
  assign MemDB = (!RamCS && !MemOE) ? dev_mem[MemAdr[5:0]] : 16'hzzzz;

  initial forever begin
    @(negedge clk);
    if (resetn && !RamCS && !MemWR) begin
      if (!RamLB) dev_mem[MemAdr[5:0]][7:0]  = MemDB[7:0];
      if (!RamUB) dev_mem[MemAdr[5:0]][15:8] = MemDB[15:8];
    end
  end

  // ---------------- reference model ----------------
  // m_k counts clock edges since the accept edge; cycle k=0 follows that edge.
  logic          m_active = 1'b0;
  int            m_k = 0;
  logic          m_we = 1'b0;
  logic          m_burst = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0]   m_wdata = '0;
  logic [1:0]    m_be = '0;
  logic [15:0]   model_mem [64];

  function automatic int m_words();
    return (!m_we && m_burst && PAGE) ? 4 : 1;
  endfunction

  // First cycle offset at which the strobes are released.
  function automatic int m_end();
    return m_we ? WR : (RD + m_words() - 1);
  endfunction

  function automatic logic exp_ready();
    return !m_active || (m_k >= m_end() + RC - 1);
  endfunction

  function automatic logic [5:0] m_word(input int j);
    logic [1:0] lo;
    lo = m_addr[1:0] + 2'(j);
    return {m_addr[5:2], lo};
  endfunction

  function automatic logic [AW-1:0] exp_adr();
    int off;
    logic [AW-1:0] a;
    if (!m_active) return '0;
    off = (m_we || m_k < RD) ? 0 : (m_k - RD + 1);
    if (off > m_words() - 1) off = m_words() - 1;
    a = m_addr;
    a[1:0] = m_addr[1:0] + 2'(off);
    return a;
  endfunction

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_active = 1'b0;
      m_k = 0;
    end else begin
      cyc++;
      if (bus.req_valid && exp_ready()) begin
        m_active = 1'b1;
        m_k      = 0;
        m_we     = bus.req_we;
        m_burst  = bus.req_burst;
        m_addr   = bus.req_addr;
        m_wdata  = bus.req_wdata;
        m_be     = bus.req_be;
        if (m_we) begin
          if (m_be[0]) model_mem[m_addr[5:0]][7:0]  = m_wdata[7:0];
          if (m_be[1]) model_mem[m_addr[5:0]][15:8] = m_wdata[15:8];
        end
      end else if (m_active && m_k < 1000) begin
        m_k++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic e_cs, e_rv;
    @(negedge clk);
    if (!resetn) begin
      chk("rst_strobes", 32'({MemOE, MemWR, RamCS, RamLB, RamUB}), 32'h1F);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rdata", 32'(bus.rsp_rdata), 32'h0);
      chk("rst_adr", 32'(MemAdr), 32'h0);
    end else begin
      e_cs = m_active && (m_k < m_end());
      e_rv = m_active && !m_we && (m_k >= RD) && (m_k < RD + m_words());
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
      chk("RamCS", 32'(RamCS), 32'(!e_cs));
      chk("MemOE", 32'(MemOE), 32'(!(e_cs && !m_we)));
      chk("MemWR", 32'(MemWR), 32'(!(e_cs && m_we)));
      chk("strobe_overlap", 32'(!MemOE && !MemWR), 32'h0);
      chk("MemAdr", 32'(MemAdr), 32'(exp_adr()));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      if (e_rv) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(model_mem[m_word(m_k - RD)]));
      if (e_cs) chk("byte_lanes", 32'({RamUB, RamLB}), 32'(2'(~m_be)));
      if (m_active && m_we && m_k <= WR) chk("MemDB_write", 32'(MemDB), 32'(m_wdata));
      chk("ties", 32'({RamAdv, RamClk, RamCRE, FlashCS, FlashRp}), 32'h03);
    end
  end

  // ---------------- directed stimulus helpers ----------------
  logic        p_oe [16];
  logic        p_wr [16];
  logic        p_rv [16];
  logic        p_rdy[16];
  logic        p_lb [16];
  logic        p_ub [16];
  logic [15:0] p_rd [16];
  logic [15:0] p_db [16];

  task automatic do_req(input logic we, input logic burst, input logic [AW-1:0] a,
                        input logic [15:0] d, input logic [1:0] be);
    int w;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_burst = burst;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", 32'(w < 50), 32'h1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    // Request inputs must be ignored outside the handshake cycle.
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = '1;
    bus.req_wdata = 16'h5A5A;
    bus.req_be    = ~be;
  endtask

  task automatic probe(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      p_oe[k]  = MemOE;
      p_wr[k]  = MemWR;
      p_rv[k]  = bus.rsp_valid;
      p_rdy[k] = bus.req_ready;
      p_lb[k]  = RamLB;
      p_ub[k]  = RamUB;
      p_rd[k]  = bus.rsp_rdata;
      p_db[k]  = MemDB;
    end
  endtask

  function automatic int cnt_low_oe(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (!p_oe[k]) c++;
    return c;
  endfunction

  function automatic int cnt_low_wr(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (!p_wr[k]) c++;
    return c;
  endfunction

  function automatic int cnt_rv(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (p_rv[k]) c++;
    return c;
  endfunction

  int acc_t [3];

  initial begin
    for (int i = 0; i < 64; i++) begin
      dev_mem[i]   = init_val(i);
      model_mem[i] = init_val(i);
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_burst = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("ready_after_reset", 32'(bus.req_ready), 32'h1);

    // Single read of 0x10 -> 0xBEEF at offset 4, OE low 4 cycles.
    do_req(1'b0, 1'b0, 23'h000010, 16'h0, 2'b11);
    probe(8);
    chk("rd_oe_cycles", 32'(cnt_low_oe(8)), 32'd4);
    chk("rd_rsp_count", 32'(cnt_rv(8)), 32'd1);
    chk("rd_rsp_at_4", 32'(p_rv[4]), 32'h1);
    chk("rd_data", 32'(p_rd[4]), 32'hBEEF);
    chk("rd_ready_k3", 32'(p_rdy[3]), 32'h0);
    chk("rd_ready_k4", 32'(p_rdy[4]), 32'h1);

    // Write 0x20 = 0x1234, lower byte only.
    do_req(1'b1, 1'b0, 23'h000020, 16'h1234, 2'b01);
    probe(8);
    chk("wr_we_cycles", 32'(cnt_low_wr(8)), 32'd4);
    chk("wr_lanes", 32'({p_ub[0], p_lb[0]}), 32'h2);
    chk("wr_db_k0", 32'(p_db[0]), 32'h1234);
    chk("wr_db_hold", 32'(p_db[4]), 32'h1234);
    chk("wr_we_high_in_hold", 32'(p_wr[4]), 32'h1);
    chk("wr_no_rsp", 32'(cnt_rv(8)), 32'd0);

    // Write then immediate read of the same address.
    do_req(1'b1, 1'b0, 23'h000020, 16'h1234, 2'b01);
    do_req(1'b0, 1'b0, 23'h000020, 16'h0, 2'b11);
    probe(8);
    chk("wr_rd_data", 32'(p_rd[4]), 32'h1234);
    chk("wr_rd_rsp", 32'(p_rv[4]), 32'h1);

    // Byte enables 00 leave memory untouched; upper-only write.
    do_req(1'b1, 1'b0, 23'h000021, 16'hFFFF, 2'b00);
    do_req(1'b0, 1'b0, 23'h000021, 16'h0, 2'b11);
    probe(8);
    chk("be00_data", 32'(p_rd[4]), 32'h1221);
    do_req(1'b1, 1'b0, 23'h000022, 16'hABCD, 2'b10);
    do_req(1'b0, 1'b0, 23'h000022, 16'h0, 2'b11);
    probe(8);
    chk("be10_data", 32'(p_rd[4]), 32'hAB22);

    // Page-mode read of 0x06 (single word when page mode is compiled out).
    do_req(1'b0, 1'b1, 23'h000006, 16'h0, 2'b11);
    probe(12);
    if (PAGE) begin
      chk("pg_count", 32'(cnt_rv(12)), 32'd4);
      chk("pg_w0", 32'({15'h0, p_rv[4]} << 16 | 32'(p_rd[4])), 32'h0001_1206);
      chk("pg_w1", 32'({15'h0, p_rv[5]} << 16 | 32'(p_rd[5])), 32'h0001_1207);
      chk("pg_w2", 32'({15'h0, p_rv[6]} << 16 | 32'(p_rd[6])), 32'h0001_1204);
      chk("pg_w3", 32'({15'h0, p_rv[7]} << 16 | 32'(p_rd[7])), 32'h0001_1205);
      chk("pg_oe_cycles", 32'(cnt_low_oe(12)), 32'd7);
    end else begin
      chk("nopg_count", 32'(cnt_rv(12)), 32'd1);
      chk("nopg_data", 32'(p_rd[4]), 32'h1206);
      chk("nopg_oe_cycles", 32'(cnt_low_oe(12)), 32'd4);
    end

    // req_valid held high: one accept every RD+RC cycles.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_burst = 1'b0;
    bus.req_be    = 2'b11;
    for (int i = 0; i < 3; i++) begin
      int w;
      w = 0;
      bus.req_addr = 23'(8 + i);
      while (!bus.req_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("stream_timeout", 32'(w < 50), 32'h1);
      @(posedge clk);
      #1;
      acc_t[i] = cyc;
    end
    bus.req_valid = 1'b0;
    chk("stream_gap01", 32'(acc_t[1] - acc_t[0]), 32'd5);
    chk("stream_gap12", 32'(acc_t[2] - acc_t[1]), 32'd5);
    probe(8);
    chk("stream_last_data", 32'(p_rd[4]), 32'h120A);

    // Reset two edges into a read aborts it immediately.
    do_req(1'b0, 1'b0, 23'h000010, 16'h0, 2'b11);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("abort_strobes", 32'({MemOE, MemWR, RamCS}), 32'h7);
    chk("abort_adr", 32'(MemAdr), 32'h0);
    chk("abort_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("abort_db_free", 32'(MemOE && !RamCS), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    probe(10);
    chk("abort_no_rsp", 32'(cnt_rv(10)), 32'd0);
    chk("abort_ready", 32'(p_rdy[0]), 32'h1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
